// File: rtl/quad_step_decoder.sv
`timescale 1ns/1ps
// quad_step_decoder
//   Quadrature (A/B) step decoder. Synchronizes the two encoder phases,
//   compares each new sample against the previous one and turns legal
//   Gray-code transitions into a signed up/down position count, a
//   direction bit and a one-cycle step pulse. A sample in which both
//   phases changed is an illegal transition and sets a sticky error flag.
//
//   Up sequence (A leads B):   00 -> 10 -> 11 -> 01 -> 00
//   Down sequence:             00 -> 01 -> 11 -> 10 -> 00
//
// Ports
//   c        clock, all state updates on the rising edge
//   r        asynchronous reset, active-low
//   a_in     encoder phase A (asynchronous to c)
//   b_in     encoder phase B (asynchronous to c)
//   en       count enable; phase tracking continues while low
//   clr      synchronous clear of the position count (wins over a step)
//   err_clr  synchronous clear of err (a new illegal transition wins)
//   q        signed position count, WIDTH bits
//   dir      direction of the last counted step, 1 = up, 0 = down
//   step     registered one-cycle pulse per counted step
//   err      sticky illegal-transition flag
//
// Latency: an edge on a_in/b_in reaches q/step after SYNC_STAGES+1 clocks.

module quad_step_decoder #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter bit WRAP        = 1'b1
) (
  input  logic                    c,
  input  logic                    r,
  input  logic                    a_in,
  input  logic                    b_in,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    err_clr,
  output logic signed [WIDTH-1:0] q,
  output logic                    dir,
  output logic                    step,
  output logic                    err
);

  localparam logic signed [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] Q_ONE = WIDTH'(1);

  // Input synchronizers; bit 0 faces the pin, the top bit is the sample.
  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
    end
  end

  logic [1:0] s;
  assign s = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

  // prev holds the last sample; primed marks that prev is meaningful.
  // The first sample after reset only loads prev and is never counted.
  logic [1:0] prev;
  logic       primed;

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      prev   <= 2'b00;
      primed <= 1'b0;
    end else begin
      prev   <= s;
      primed <= 1'b1;
    end
  end

  // Transition classification of prev -> s.
  logic is_up;
  logic is_dn;
  logic is_illegal;

  always_comb begin
    is_up = 1'b0;
    is_dn = 1'b0;
    case ({prev, s})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_up = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_dn = 1'b1;
      default: ;
    endcase
  end

  assign is_illegal = primed && ((prev ^ s) == 2'b11);

  logic count_up;
  logic count_dn;
  assign count_up = primed && en && is_up;
  assign count_dn = primed && en && is_dn;

  // Next count: wrap naturally through two's-complement overflow, or
  // clamp at the limits when WRAP is 0. clr overrides any step.
  logic signed [WIDTH-1:0] q_next;

  always_comb begin
    q_next = q;
    if (count_up) begin
      if (!WRAP && (q == Q_MAX)) q_next = q;
      else                       q_next = q + Q_ONE;
    end else if (count_dn) begin
      if (!WRAP && (q == Q_MIN)) q_next = q;
      else                       q_next = q - Q_ONE;
    end
    if (clr) q_next = '0;
  end

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      q    <= '0;
      dir  <= 1'b0;
      step <= 1'b0;
      err  <= 1'b0;
    end else begin
      q    <= q_next;
      step <= count_up || count_dn;
      // dir follows counted steps only, so it also updates under clr
      // and at the saturation limits.
      if (count_up)      dir <= 1'b1;
      else if (count_dn) dir <= 1'b0;
      // Set has priority over err_clr so a fresh fault is never lost.
      if (is_illegal)    err <= 1'b1;
      else if (err_clr)  err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
`timescale 1ns/1ps
// Bench for quad_step_decoder: a 32-bit wrapping instance plus two 4-bit
// instances (wrapping and saturating) sharing the encoder phases.

module tb_quad_step_decoder;

  // ---------------- clock / reset ----------------
  logic c = 1'b0;
  always #5 c = ~c;

  logic r, a_in, b_in, en, en_n, clr, err_clr;

  logic signed [31:0] q;
  logic               dir, step, err;
  logic        [3:0]  q_w, q_s;
  logic               dir_w, step_w, err_w;
  logic               dir_s, step_s, err_s;

  quad_step_decoder #(.WIDTH(32), .SYNC_STAGES(2), .WRAP(1'b1)) dut (
    .c(c), .r(r), .a_in(a_in), .b_in(b_in), .en(en), .clr(clr),
    .err_clr(err_clr), .q(q), .dir(dir), .step(step), .err(err)
  );

  quad_step_decoder #(.WIDTH(4), .SYNC_STAGES(2), .WRAP(1'b1)) dut_w (
    .c(c), .r(r), .a_in(a_in), .b_in(b_in), .en(en_n), .clr(clr),
    .err_clr(err_clr), .q(q_w), .dir(dir_w), .step(step_w), .err(err_w)
  );

  quad_step_decoder #(.WIDTH(4), .SYNC_STAGES(2), .WRAP(1'b0)) dut_s (
    .c(c), .r(r), .a_in(a_in), .b_in(b_in), .en(en_n), .clr(clr),
    .err_clr(err_clr), .q(q_s), .dir(dir_s), .step(step_s), .err(err_s)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int step_cnt = 0;
  int step_w_cnt = 0;
  int step_s_cnt = 0;

  logic [31:0] exp_q[$];
  logic [3:0]  exp_w_q[$];
  logic [3:0]  exp_s_q[$];

  logic [31:0] model_q;
  logic [3:0]  model_w, model_s;
  int          ph;  // index into the up sequence 00,10,11,01

  // Each step pulse pops the expected count and compares it with q.
  always @(negedge c) begin
    logic [31:0] e;
    logic [3:0]  e4;
    if (r) begin
      if (step) begin
        step_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_step q=%0d", q);
        end else begin
          e = exp_q.pop_front();
          if (q !== e) begin
            n_bad++;
            $display("FAIL step_q got=%0d exp=%0d", q, $signed(e));
          end
        end
      end
      if (step_w) begin
        step_w_cnt++;
        n_cmp++;
        if (exp_w_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_step_w q=%h", q_w);
        end else begin
          e4 = exp_w_q.pop_front();
          if (q_w !== e4) begin
            n_bad++;
            $display("FAIL step_q_wrap got=%h exp=%h", q_w, e4);
          end
        end
      end
      if (step_s) begin
        step_s_cnt++;
        n_cmp++;
        if (exp_s_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_step_s q=%h", q_s);
        end else begin
          e4 = exp_s_q.pop_front();
          if (q_s !== e4) begin
            n_bad++;
            $display("FAIL step_q_sat got=%h exp=%h", q_s, e4);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // delta: 1 = up step, 3 = down step, 2 = both phases toggle (illegal).
  // Optional clr / err_clr are asserted in the cycle the DUT acts on the
  // new sample. stp_obs is step sampled right after that edge.
  task automatic drive_step(input int delta, input bit with_clr,
                            input bit with_eclr, output logic stp_obs);
    logic [1:0] seq [4];
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    @(negedge c);
    ph = (ph + delta) % 4;
    {a_in, b_in} = seq[ph];
    repeat (2) @(posedge c);
    #1;
    clr     = with_clr;
    err_clr = with_eclr;
    @(posedge c);
    #1;
    stp_obs = step;
    clr     = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0 && exp_w_q.size() == 0 && exp_s_q.size() == 0) break;
      @(negedge c);
    end
    n_cmp++;
    if (exp_q.size() + exp_w_q.size() + exp_s_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain pending=%0d exp=0", tag,
               exp_q.size() + exp_w_q.size() + exp_s_q.size());
    end
    exp_q.delete(); exp_w_q.delete(); exp_s_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    r = 1'b0; a_in = 1'b0; b_in = 1'b0; en = 1'b1; en_n = 1'b0;
    clr = 1'b0; err_clr = 1'b0; ph = 0;
    model_q = '0; model_w = '0; model_s = '0;
    repeat (3) @(negedge c);
    n_cmp += 4;
    if (q !== 32'sd0) begin n_bad++; $display("FAIL reset_q got=%0d exp=0", q); end
    if (dir !== 1'b0) begin n_bad++; $display("FAIL reset_dir got=%b exp=0", dir); end
    if (step !== 1'b0) begin n_bad++; $display("FAIL reset_step got=%b exp=0", step); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    r = 1'b1;
    repeat (4) @(negedge c);
    n_cmp++;
    if (step_cnt !== 0) begin n_bad++; $display("FAIL prime_no_step got=%0d exp=0", step_cnt); end
  endtask

  task automatic test_up();
    logic s_o;
    int   c0 = step_cnt;
    for (int i = 0; i < 8; i++) begin
      model_q = model_q + 32'd1;
      exp_q.push_back(model_q);
      drive_step(1, 1'b0, 1'b0, s_o);
      n_cmp++;
      if (s_o !== 1'b1) begin n_bad++; $display("FAIL up_latency i=%0d step=%b exp=1", i, s_o); end
    end
    wait_drain("up");
    n_cmp += 4;
    if (q !== 32'sd8) begin n_bad++; $display("FAIL up_q got=%0d exp=8", q); end
    if (dir !== 1'b1) begin n_bad++; $display("FAIL up_dir got=%b exp=1", dir); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL up_err got=%b exp=0", err); end
    if (step_cnt - c0 !== 8) begin n_bad++; $display("FAIL up_pulses got=%0d exp=8", step_cnt - c0); end
  endtask

  task automatic test_down();
    logic s_o;
    for (int i = 0; i < 10; i++) begin
      model_q = model_q - 32'd1;
      exp_q.push_back(model_q);
      drive_step(3, 1'b0, 1'b0, s_o);
    end
    wait_drain("down");
    n_cmp += 3;
    if (q !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL down_q got=%h exp=fffffffe", q); end
    if (dir !== 1'b0) begin n_bad++; $display("FAIL down_dir got=%b exp=0", dir); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL down_err got=%b exp=0", err); end
  endtask

  task automatic test_wrap_sat();
    logic s_o;
    en_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      model_q = model_q + 32'd1;
      model_w = model_w + 4'd1;
      model_s = (model_s == 4'd7) ? 4'd7 : model_s + 4'd1;
      exp_q.push_back(model_q);
      exp_w_q.push_back(model_w);
      exp_s_q.push_back(model_s);
      drive_step(1, 1'b0, 1'b0, s_o);
    end
    wait_drain("wrap");
    en_n = 1'b0;
    n_cmp += 7;
    if (q_w !== 4'b1000) begin n_bad++; $display("FAIL wrap_q got=%h exp=8", q_w); end
    if (q_s !== 4'b0111) begin n_bad++; $display("FAIL sat_q got=%h exp=7", q_s); end
    if (step_s_cnt !== 8) begin n_bad++; $display("FAIL sat_pulses got=%0d exp=8", step_s_cnt); end
    if (step_w_cnt !== 8) begin n_bad++; $display("FAIL wrap_pulses got=%0d exp=8", step_w_cnt); end
    if (dir_w !== 1'b1) begin n_bad++; $display("FAIL wrap_dir got=%b exp=1", dir_w); end
    if (dir_s !== 1'b1) begin n_bad++; $display("FAIL sat_dir got=%b exp=1", dir_s); end
    if ((err_w | err_s) !== 1'b0) begin n_bad++; $display("FAIL narrow_err got=%b exp=0", err_w | err_s); end
  endtask

  task automatic test_illegal();
    logic s_o;
    drive_step(2, 1'b0, 1'b0, s_o);
    @(negedge c);
    n_cmp += 4;
    if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_err got=%b exp=1", err); end
    if (q !== model_q) begin n_bad++; $display("FAIL illegal_q got=%0d exp=%0d", q, $signed(model_q)); end
    if (s_o !== 1'b0) begin n_bad++; $display("FAIL illegal_step got=%b exp=0", s_o); end
    if (dir !== 1'b1) begin n_bad++; $display("FAIL illegal_dir got=%b exp=1", dir); end
    err_clr = 1'b1;
    @(negedge c);
    err_clr = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL err_clr got=%b exp=0", err); end
    // err_clr in the same cycle as a new illegal transition
    drive_step(2, 1'b0, 1'b1, s_o);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL err_set_wins got=%b exp=1", err); end
    @(negedge c);
    err_clr = 1'b1;
    @(negedge c);
    err_clr = 1'b0;
    wait_drain("illegal");
  endtask

  task automatic test_enable();
    logic s_o;
    @(negedge c);
    clr = 1'b1;
    @(negedge c);
    clr = 1'b0;
    model_q = '0;
    n_cmp++;
    if (q !== 32'sd0) begin n_bad++; $display("FAIL clr_q got=%0d exp=0", q); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_step(1, 1'b0, 1'b0, s_o);
      n_cmp++;
      if (s_o !== 1'b0) begin n_bad++; $display("FAIL en0_step i=%0d got=%b exp=0", i, s_o); end
    end
    en = 1'b1;
    model_q = 32'd1;
    exp_q.push_back(model_q);
    drive_step(1, 1'b0, 1'b0, s_o);
    wait_drain("enable");
    n_cmp += 3;
    if (s_o !== 1'b1) begin n_bad++; $display("FAIL en1_step got=%b exp=1", s_o); end
    if (q !== 32'sd1) begin n_bad++; $display("FAIL en_q got=%0d exp=1", q); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL en_err got=%b exp=0", err); end
  endtask

  task automatic test_clr_step();
    logic s_o;
    for (int i = 0; i < 4; i++) begin
      model_q = model_q + 32'd1;
      exp_q.push_back(model_q);
      drive_step(1, 1'b0, 1'b0, s_o);
    end
    n_cmp++;
    if (q !== 32'sd5) begin n_bad++; $display("FAIL pre_clr_q got=%0d exp=5", q); end
    model_q = '0;
    exp_q.push_back(model_q);
    drive_step(1, 1'b1, 1'b0, s_o);
    n_cmp += 3;
    if (s_o !== 1'b1) begin n_bad++; $display("FAIL clr_step_pulse got=%b exp=1", s_o); end
    if (q !== 32'sd0) begin n_bad++; $display("FAIL clr_step_q got=%0d exp=0", q); end
    if (dir !== 1'b1) begin n_bad++; $display("FAIL clr_step_dir got=%b exp=1", dir); end
    wait_drain("clr_step");
  endtask

  task automatic test_reset_mid();
    logic s_o;
    int   c0;
    model_q = model_q + 32'd1;
    exp_q.push_back(model_q);
    drive_step(1, 1'b0, 1'b0, s_o);
    drive_step(2, 1'b0, 1'b0, s_o);
    @(posedge c);
    #2;
    r = 1'b0;
    #1;
    n_cmp += 4;
    if (q !== 32'sd0) begin n_bad++; $display("FAIL midrst_q got=%0d exp=0", q); end
    if (dir !== 1'b0) begin n_bad++; $display("FAIL midrst_dir got=%b exp=0", dir); end
    if (step !== 1'b0) begin n_bad++; $display("FAIL midrst_step got=%b exp=0", step); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL midrst_err got=%b exp=0", err); end
    a_in = 1'b0; b_in = 1'b0; ph = 0; model_q = '0;
    exp_q.delete();
    repeat (3) @(negedge c);
    r = 1'b1;
    c0 = step_cnt;
    repeat (6) @(negedge c);
    n_cmp += 2;
    if (step_cnt !== c0) begin n_bad++; $display("FAIL reprime_step got=%0d exp=0", step_cnt - c0); end
    if (q !== 32'sd0) begin n_bad++; $display("FAIL reprime_q got=%0d exp=0", q); end
    model_q = 32'd1;
    exp_q.push_back(model_q);
    drive_step(1, 1'b0, 1'b0, s_o);
    n_cmp++;
    if (s_o !== 1'b1) begin n_bad++; $display("FAIL post_rst_step got=%b exp=1", s_o); end
    wait_drain("reset_mid");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_up();
    test_down();
    test_wrap_sat();
    test_illegal();
    test_enable();
    test_clr_step();
    test_reset_mid();
    repeat (2) @(negedge c);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
